rom_seq_ctrl: RTL

Sequencer that plays a pattern out of the 16x8 lookup ROM. It walks the ROM address range from a start address to an end address, holding each entry for a programmable number of clocks. Modes are one-shot or continuous loop, with start/stop pulse control. It sits between the board control logic (keys/config registers) and the ROM, and drives the LED/pattern output.

---
 rtl/rom_seq_pkg.sv | 15 +
 rtl/step_timer.sv | 28 ++
 rtl/rom_seq_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/rom_seq_pkg.sv
// Shared definitions for the ROM pattern sequencer: default widths and the FSM state encoding.
package rom_seq_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 4;
    localparam int unsigned DATA_W_DEFAULT = 8;
    localparam int unsigned HOLD_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2,
        StDone  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter that times the hold phase of each sequencer step.
module step_timer #(
    parameter int unsigned HOLD_W = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [HOLD_W-1:0] load_val,
    output logic              zero
);

    logic [HOLD_W-1:0] cnt_q;

    // Load has priority; counting stops at zero so the flag stays asserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - HOLD_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/rom_seq_ctrl.sv
// Plays a pattern out of an external lookup ROM, walking start..end with a programmable hold.
module rom_seq_ctrl
    import rom_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned HOLD_W = HOLD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [HOLD_W-1:0] hold_cycles,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] pat_out,
    output logic              pat_valid,
    output logic              busy,
    output logic              done
);

    seq_state_e state_q, state_d;

    // Configuration captured at launch; the live inputs are ignored during a run.
    logic              loop_q;
    logic [ADDR_W-1:0] start_q;
    logic [ADDR_W-1:0] end_q;
    logic [HOLD_W-1:0] hold_q;

    logic [ADDR_W-1:0] rom_addr_q;
    logic [DATA_W-1:0] pat_out_q;
    logic              pat_valid_q;
    logic              done_q;

    logic launch;
    logic timer_load;
    logic timer_en;
    logic timer_zero;
    logic step_end;
    logic at_end;
    logic finish;

    assign at_end = (rom_addr_q == end_q);
    assign finish = step_end && at_end && !loop_q;

    step_timer #(
        .HOLD_W (HOLD_W)
    ) u_step_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .en       (timer_en),
        .load_val (hold_q),
        .zero     (timer_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop beats every other transition except leaving DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = stop ? StIdle : StHold;
            end
            StHold: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (timer_zero) begin
                    state_d = (at_end && !loop_q) ? StDone : StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        busy       = (state_q != StIdle);
        launch     = (state_q == StIdle) && start && !stop;
        timer_load = (state_q == StFetch) && !stop;
        timer_en   = (state_q == StHold) && !stop && !timer_zero;
        step_end   = (state_q == StHold) && !stop && timer_zero;
    end

    // Datapath: config latch, address walk, pattern capture and the two output pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loop_q      <= 1'b0;
            start_q     <= '0;
            end_q       <= '0;
            hold_q      <= '0;
            rom_addr_q  <= '0;
            pat_out_q   <= '0;
            pat_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pat_valid_q <= timer_load;
            done_q      <= finish;
            if (launch) begin
                loop_q     <= loop_en;
                start_q    <= start_addr;
                end_q      <= end_addr;
                hold_q     <= hold_cycles;
                rom_addr_q <= start_addr;
            end
            if (timer_load) begin
                pat_out_q <= rom_data;
            end
            // Address wraps modulo 2^ADDR_W, so end < start walks through the top of the ROM.
            if (step_end && !finish) begin
                rom_addr_q <= at_end ? start_q : rom_addr_q + ADDR_W'(1);
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pat_out   = pat_out_q;
    assign pat_valid = pat_valid_q;
    assign done      = done_q;

endmodule
